key_order_encoder: RTL
======================

# key_order_encoder

Producer side of the move-order interface: converts five raw push-buttons (up, down, left, right, enter) into the 3-bit order code plus one-cycle work strobe consumed by the game-step logic. One instance per human player. Each instance drives one od/wk pair and is gated by that player's enable. The block covers synchronisation, debounce, press detection, priority arbitration and auto-repeat for cursor moves.

## Interface
- DEB_CYCLES, 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- REPEAT_EN, 1: 1 enables auto-repeat of direction keys; 0 disables it.
- REPEAT_DELAY, 50_000_000: cycles a direction key must stay held after its order before the first repeat.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent repeats.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_up, btn_down, btn_left, btn_right, btn_enter  in  1 each  raw, asynchronous, active-high button levels.
- ena  in  1  this player currently owns the order interface.
- od  out  3  order code: NULL 000, UP 001, DOWN 010, LEFT 011, RIGHT 100, ENTER 101.
- wk  out  1  one-cycle strobe; od is valid only while wk=1.

## Operation
- Reset values: od=NULL, wk=0. All debounced levels=0, all pending bits=0, repeat FSM=IDLE, all counters=0.
- Sync: each button passes through a 2-FF synchroniser.
- Debounce:
  - Counter increments while the synchronised level differs from the debounced level.
  - The counter clears whenever the two are equal.
  - When the counter reaches DEB_CYCLES, the debounced level flips and the counter clears.
- Press: a debounced 0→1 transition sets that key's pending bit, but only if ena=1. Releases generate nothing.
- Arbitration: one order per cycle. Priority is ENTER > UP > DOWN > LEFT > RIGHT.
  - The winning pending bit is cleared and registered onto od/wk.
  - Lower-priority pending bits wait for later cycles.
- ena=0: all pending bits clear, repeat FSM returns to IDLE, od=NULL, wk=0. Presses occurring while ena=0 are discarded, not queued.
- Repeat FSM, held key K:
  - IDLE: when a direction order K is emitted → DELAY, with timer cleared.
  - DELAY: timer counts up. On reaching REPEAT_DELAY with K still debounced-high, set pending[K] → PERIOD, timer cleared.
  - PERIOD: at REPEAT_PERIOD with K still high, set pending[K] and clear the timer.
  - From any state, go to IDLE on: K released, emission of any order other than K, ena=0, or REPEAT_EN=0.
  - An emitted ENTER forces IDLE. ENTER never repeats.
- A repeat-set and an edge-set of the same pending bit in one cycle merge into a single pending order.

## Timing
- Raw rise to wk=1: DEB_CYCLES+3 cycles when uncontended. The breakdown is 2 cycles sync, DEB_CYCLES debounce, 1 cycle output register.
- wk is high for exactly one cycle per order. There are no back-to-back duplicates except when separate pending keys are served.
- Simultaneous presses are served on consecutive cycles in priority order.
- Holding a direction key produces orders at t0, t0+REPEAT_DELAY, then every REPEAT_PERIOD, each ±1 cycle of FSM latency, fixed and deterministic.
- Reset mid-operation immediately forces the reset values.
- If a button is still held when rst_n releases, it debounces and yields one press DEB_CYCLES+3 cycles later, provided ena=1.
- Counter widths: $clog2(max(parameter)+1). Counters never wrap, because they clear at their terminal value.

## Structure
- Shared package `order_pkg`:
  - order code constants NULL/UP/DOWN/LEFT/RIGHT/ENTER, also used by the game-step logic;
  - key index constants for the pending vector.
- Sub-module `key_debounce`, instantiated 5 times. It contains the synchroniser, debounce counter and registered debounced level, and provides a one-cycle rise pulse.
- The top level holds the pending vector, priority encoder, repeat FSM/timer and output register.

## Test plan
All scenarios run with DEB_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8.
- Reset: hold rst_n=0 with buttons toggling → od=000, wk=0 throughout. Release with all buttons low → no wk for 100 cycles.
- Single press: ena=1, btn_down 0→1 held 5 cycles → exactly one wk with od=010, DEB_CYCLES+3=7 cycles after the rise.
- Bounce: btn_up toggling every 2 cycles for 20 cycles, then steady high → single od=001 strobe 7 cycles after the steady level begins.
- Simultaneous: btn_enter and btn_left rise in the same cycle → od=101 then od=011 on the next cycle, wk=1 both cycles.
- Auto-repeat: btn_right held 60 cycles → od=100 strobes at t0, t0+16, t0+24, t0+32, … Releasing stops strobes. The same hold on btn_enter gives exactly one 101.
- Enable gating: press btn_up with ena=0 → no wk; raising ena afterwards while still held gives no strobe. Dropping ena mid-repeat stops strobes immediately.

Source files
------------

// File: rtl/key_order_encoder_pkg.sv
// order_pkg: order codes shared with the game-step logic, key indices for the
// pending vector, and the auto-repeat state encoding.
package order_pkg;

  // Order codes carried on od while wk=1.
  localparam logic [2:0] ORD_NULL  = 3'b000;
  localparam logic [2:0] ORD_UP    = 3'b001;
  localparam logic [2:0] ORD_DOWN  = 3'b010;
  localparam logic [2:0] ORD_LEFT  = 3'b011;
  localparam logic [2:0] ORD_RIGHT = 3'b100;
  localparam logic [2:0] ORD_ENTER = 3'b101;

  // Bit positions of each key in the debounced / pending vectors.
  localparam int NUM_KEYS = 5;
  typedef logic [2:0] key_idx_t;
  localparam key_idx_t K_UP    = 3'd0;
  localparam key_idx_t K_DOWN  = 3'd1;
  localparam key_idx_t K_LEFT  = 3'd2;
  localparam key_idx_t K_RIGHT = 3'd3;
  localparam key_idx_t K_ENTER = 3'd4;

  // Auto-repeat states for the held direction key.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_PERIOD = 2'd2
  } rpt_state_e;

  // Map a key index to the order code it produces.
  function automatic logic [2:0] key_to_order(input key_idx_t key);
    case (key)
      K_UP:    return ORD_UP;
      K_DOWN:  return ORD_DOWN;
      K_LEFT:  return ORD_LEFT;
      K_RIGHT: return ORD_RIGHT;
      K_ENTER: return ORD_ENTER;
      default: return ORD_NULL;
    endcase
  endfunction

endpackage

// File: rtl/key_order_encoder_debounce.sv
// key_debounce: 2-FF synchroniser, stability counter and debounced level for
// one raw button. rise pulses for one cycle, in the first cycle the debounced
// level reads 1 after a 0->1 acceptance.
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  // The flip happens on the DEB_CYCLES-th consecutive differing cycle, so the
  // counter never needs to hold DEB_CYCLES itself.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser for the asynchronous button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  // Stability counter: accept a new level only after it held for DEB_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else if (sync_q2 == level) begin
      cnt  <= '0;
      rise <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync_q2;
      rise  <= sync_q2;
    end else begin
      cnt  <= cnt + CW'(1);
      rise <= 1'b0;
    end
  end

endmodule

// File: rtl/key_order_encoder.sv
// key_order_encoder: turns five raw push-buttons into order codes for one
// player. Debounced presses queue in a pending vector, a fixed-priority
// encoder picks one per cycle, and a repeat FSM re-queues a held direction.
//
// Output semantics: od/wk is a push-only strobe with no back-pressure. wk is
// high for exactly one cycle per order and od is meaningful only while wk=1
// (it reads ORD_NULL otherwise).
module key_order_encoder
  import order_pkg::*;
#(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_enter,
  input  logic       ena,
  output logic [2:0] od,
  output logic       wk,
  output logic [1:0] dbg_state
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW      = $clog2(RPT_MAX + 1);
  // Terminal compare is one below the target so the re-queued order is
  // emitted exactly REPEAT_DELAY / REPEAT_PERIOD cycles after the previous one.
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic [NUM_KEYS-1:0] btn_raw;
  logic [NUM_KEYS-1:0] deb_level;
  logic [NUM_KEYS-1:0] deb_rise;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] rep_set;
  logic [NUM_KEYS-1:0] req;
  logic [NUM_KEYS-1:0] win_mask;
  logic                win_vld;
  key_idx_t            win_idx;
  logic                emit_dir;

  rpt_state_e          rpt_state;
  key_idx_t            rep_key;
  logic [TW-1:0]       timer;

  assign btn_raw[K_UP]    = btn_up;
  assign btn_raw[K_DOWN]  = btn_down;
  assign btn_raw[K_LEFT]  = btn_left;
  assign btn_raw[K_RIGHT] = btn_right;
  assign btn_raw[K_ENTER] = btn_enter;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_raw[k]),
      .level(deb_level[k]),
      .rise (deb_rise[k])
    );
  end

  // Repeat request: the tracked key is still held and its timer hit terminal.
  always_comb begin
    rep_set = '0;
    if (REPEAT_EN != 0 && rpt_state != RPT_IDLE && deb_level[rep_key]) begin
      if ((rpt_state == RPT_DELAY  && timer == DELAY_LAST) ||
          (rpt_state == RPT_PERIOD && timer == PERIOD_LAST)) begin
        rep_set[rep_key] = 1'b1;
      end
    end
  end

  // Requests this cycle: queued orders plus fresh presses plus repeats; an
  // edge and a repeat on the same key simply OR into one request.
  always_comb begin
    req = pending | rep_set;
    if (ena) begin
      req = req | deb_rise;
    end
  end

  // Fixed priority ENTER > UP > DOWN > LEFT > RIGHT.
  always_comb begin
    win_vld  = 1'b1;
    win_idx  = K_ENTER;
    win_mask = '0;
    if (req[K_ENTER]) begin
      win_idx = K_ENTER;
    end else if (req[K_UP]) begin
      win_idx = K_UP;
    end else if (req[K_DOWN]) begin
      win_idx = K_DOWN;
    end else if (req[K_LEFT]) begin
      win_idx = K_LEFT;
    end else if (req[K_RIGHT]) begin
      win_idx = K_RIGHT;
    end else begin
      win_vld = 1'b0;
    end
    if (win_vld) begin
      win_mask[win_idx] = 1'b1;
    end
  end

  assign emit_dir = win_vld && (win_idx != K_ENTER);

  // Pending vector, output register and repeat FSM/timer, all dropped by ena=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      od        <= ORD_NULL;
      wk        <= 1'b0;
      rpt_state <= RPT_IDLE;
      rep_key   <= K_UP;
      timer     <= '0;
    end else if (!ena) begin
      pending   <= '0;
      od        <= ORD_NULL;
      wk        <= 1'b0;
      rpt_state <= RPT_IDLE;
      timer     <= '0;
    end else begin
      pending <= req & ~win_mask;
      wk      <= win_vld;
      od      <= win_vld ? key_to_order(win_idx) : ORD_NULL;

      if (REPEAT_EN == 0) begin
        rpt_state <= RPT_IDLE;
        timer     <= '0;
      end else begin
        case (rpt_state)
          RPT_IDLE: begin
            // A freshly emitted direction becomes the key we watch.
            if (emit_dir) begin
              rpt_state <= RPT_DELAY;
              rep_key   <= win_idx;
              timer     <= '0;
            end
          end
          RPT_DELAY, RPT_PERIOD: begin
            // Any other order (including ENTER) or a release ends the repeat.
            if ((win_vld && win_idx != rep_key) || !deb_level[rep_key]) begin
              rpt_state <= RPT_IDLE;
              timer     <= '0;
            end else if (rpt_state == RPT_DELAY && timer == DELAY_LAST) begin
              rpt_state <= RPT_PERIOD;
              timer     <= '0;
            end else if (rpt_state == RPT_PERIOD && timer == PERIOD_LAST) begin
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            rpt_state <= RPT_IDLE;
            timer     <= '0;
          end
        endcase
      end
    end
  end

  assign dbg_state = rpt_state;

endmodule
